// File: rtl/axis_fifo_if.sv
// ---------------------------------------------------------------------------
// axis_fifo_if
// AXI4-Stream bundle used on both sides of axis_fifo.
//   master modport : drives tdata/tkeep/tvalid/tlast/tid/tdest/tuser, samples tready
//   slave modport  : samples the payload and tvalid, drives tready
// Parameters set the payload and sideband widths and must match the FIFO
// instance the bundle is attached to.
// ---------------------------------------------------------------------------
interface axis_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_fifo.sv
// ---------------------------------------------------------------------------
// axis_fifo
// Synchronous AXI4-Stream FIFO with optional frame (packet) mode.
//
// Ports:
//   clk               : single clock
//   rst               : asynchronous active-high reset, clears all state
//   s_axis (slave)    : upstream beats (tdata/tkeep/tlast/tid/tdest/tuser)
//   m_axis (master)   : downstream beats from a one-entry output register
//   status_overflow   : pulse when a frame is dropped for lack of space
//   status_bad_frame  : pulse when a frame marked bad is dropped
//   status_good_frame : pulse when a frame is committed
//
// Frame mode writes a frame speculatively behind r_wrPtrCur and only makes
// it visible to the read side (r_wrPtr) once its tlast beat is stored.
//
// Optional feature macro: AXIS_FIFO_STATUS_EN
//   defined   -> the three status outputs are registered pulses
//   undefined -> the status outputs are tied to 0
// ---------------------------------------------------------------------------
module axis_fifo #(
  parameter int DEPTH          = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int LAST_ENABLE    = 1,
  parameter int ID_ENABLE      = 0,
  parameter int ID_WIDTH       = 8,
  parameter int DEST_ENABLE    = 0,
  parameter int DEST_WIDTH     = 8,
  parameter int USER_ENABLE    = 1,
  parameter int USER_WIDTH     = 1,
  parameter int FRAME_FIFO     = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
  parameter int DROP_BAD_FRAME = 0,
  parameter int DROP_WHEN_FULL = 1
) (
  input  logic        clk,
  input  logic        rst,
  axis_fifo_if.slave  s_axis,
  axis_fifo_if.master m_axis,
  output logic        status_overflow,
  output logic        status_bad_frame,
  output logic        status_good_frame
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  localparam bit FRAME     = (FRAME_FIFO != 0);
  localparam bit DROP_BAD  = (DROP_BAD_FRAME != 0);
  localparam bit DROP_FULL = (DROP_WHEN_FULL != 0);

  // Packed storage word layout: only enabled sidebands take up storage bits.
  localparam int KEEP_OFFSET = DATA_WIDTH;
  localparam int LAST_OFFSET = KEEP_OFFSET + ((KEEP_ENABLE != 0) ? KEEP_WIDTH : 0);
  localparam int ID_OFFSET   = LAST_OFFSET + ((LAST_ENABLE != 0) ? 1 : 0);
  localparam int DEST_OFFSET = ID_OFFSET + ((ID_ENABLE != 0) ? ID_WIDTH : 0);
  localparam int USER_OFFSET = DEST_OFFSET + ((DEST_ENABLE != 0) ? DEST_WIDTH : 0);
  localparam int WIDTH       = USER_OFFSET + ((USER_ENABLE != 0) ? USER_WIDTH : 0);

  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_wrPtrCur;
  logic [PTR_W-1:0] r_rdPtr;
  logic             r_dropFrame;
  logic             r_mValid;
  logic [WIDTH-1:0] r_mWord;
  logic [WIDTH-1:0] r_mem [DEPTH];

  wire  [WIDTH-1:0] w_sWord;
  logic             w_full;
  logic             w_fullCur;
  logic             w_fullWr;
  logic             w_empty;
  logic             w_sXfer;
  logic             w_badFrame;
  logic             w_overflowEvt;
  logic             w_storeBeat;
  logic             w_badEvt;
  logic             w_goodEvt;
  logic             w_load;
  logic [AW-1:0]    w_wrAddr;

  // Sidebands that a given configuration does not store are still part of
  // the bundle; fold them here so they are visibly consumed.
  logic w_unusedSidebands;
  assign w_unusedSidebands = ^{s_axis.tkeep, s_axis.tid, s_axis.tdest,
                               s_axis.tuser, s_axis.tlast};

  // Pack the incoming beat into the storage word.
  assign w_sWord[DATA_WIDTH-1:0] = s_axis.tdata;

  generate
    if (KEEP_ENABLE != 0) begin : g_keepIn
      assign w_sWord[KEEP_OFFSET +: KEEP_WIDTH] = s_axis.tkeep;
    end
    if (LAST_ENABLE != 0) begin : g_lastIn
      assign w_sWord[LAST_OFFSET] = s_axis.tlast;
    end
    if (ID_ENABLE != 0) begin : g_idIn
      assign w_sWord[ID_OFFSET +: ID_WIDTH] = s_axis.tid;
    end
    if (DEST_ENABLE != 0) begin : g_destIn
      assign w_sWord[DEST_OFFSET +: DEST_WIDTH] = s_axis.tdest;
    end
    if (USER_ENABLE != 0) begin : g_userIn
      assign w_sWord[USER_OFFSET +: USER_WIDTH] = s_axis.tuser;
    end
  endgenerate

  // Occupancy flags; the pointer MSB distinguishes full from empty.
  assign w_full    = (r_wrPtr - r_rdPtr) == DEPTH_P;
  assign w_fullCur = (r_wrPtrCur - r_rdPtr) == DEPTH_P;
  assign w_fullWr  = (r_wrPtrCur - r_wrPtr) == DEPTH_P;
  assign w_empty   = (r_wrPtr == r_rdPtr);

  // A frame larger than the whole buffer (w_fullWr) is always accepted so
  // it can be discarded instead of deadlocking the upstream port.
  assign s_axis.tready = FRAME ? (!w_fullCur || w_fullWr || DROP_FULL) : !w_full;

  assign w_sXfer    = s_axis.tvalid && s_axis.tready;
  assign w_badFrame = DROP_BAD &&
                      ((s_axis.tuser & USER_BAD_FRAME_MASK) ==
                       (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));

  assign w_overflowEvt = FRAME && w_sXfer && !r_dropFrame && (w_fullCur || w_fullWr);
  assign w_storeBeat   = FRAME ? (w_sXfer && !r_dropFrame && !(w_fullCur || w_fullWr))
                               : w_sXfer;
  assign w_badEvt      = FRAME && w_storeBeat && s_axis.tlast && w_badFrame;
  assign w_goodEvt     = FRAME && w_storeBeat && s_axis.tlast && !w_badFrame;
  assign w_wrAddr      = FRAME ? r_wrPtrCur[AW-1:0] : r_wrPtr[AW-1:0];

  // Write-side pointer bookkeeping. Once a frame starts dropping it keeps
  // dropping through its tlast beat, regardless of space freed meanwhile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr     <= '0;
      r_wrPtrCur  <= '0;
      r_dropFrame <= 1'b0;
    end else if (!FRAME) begin
      if (w_storeBeat) begin
        r_wrPtr    <= r_wrPtr + ONE_P;
        r_wrPtrCur <= r_wrPtr + ONE_P;
      end
    end else if (w_sXfer) begin
      if (r_dropFrame) begin
        if (s_axis.tlast) begin
          r_dropFrame <= 1'b0;
        end
      end else if (w_overflowEvt) begin
        r_dropFrame <= !s_axis.tlast;
        r_wrPtrCur  <= r_wrPtr;
      end else begin
        r_wrPtrCur <= r_wrPtrCur + ONE_P;
        if (w_badEvt) begin
          r_wrPtrCur <= r_wrPtr;
        end else if (w_goodEvt) begin
          r_wrPtr <= r_wrPtrCur + ONE_P;
        end
      end
    end
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_storeBeat) begin
      r_mem[w_wrAddr] <= w_sWord;
    end
  end

  // One-entry output register, refilled whenever it is empty or being
  // consumed and committed data is waiting.
  assign w_load = (!r_mValid || m_axis.tready) && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr  <= '0;
      r_mValid <= 1'b0;
      r_mWord  <= '0;
    end else if (w_load) begin
      r_mWord  <= r_mem[r_rdPtr[AW-1:0]];
      r_mValid <= 1'b1;
      r_rdPtr  <= r_rdPtr + ONE_P;
    end else if (m_axis.tready) begin
      r_mValid <= 1'b0;
    end
  end

  // Unpack the output register; disabled sidebands take fixed values.
  assign m_axis.tvalid = r_mValid;
  assign m_axis.tdata  = r_mWord[DATA_WIDTH-1:0];

  generate
    if (KEEP_ENABLE != 0) begin : g_keepOut
      assign m_axis.tkeep = r_mWord[KEEP_OFFSET +: KEEP_WIDTH];
    end else begin : g_keepOne
      assign m_axis.tkeep = '1;
    end
    if (LAST_ENABLE != 0) begin : g_lastOut
      assign m_axis.tlast = r_mWord[LAST_OFFSET];
    end else begin : g_lastOne
      assign m_axis.tlast = 1'b1;
    end
    if (ID_ENABLE != 0) begin : g_idOut
      assign m_axis.tid = r_mWord[ID_OFFSET +: ID_WIDTH];
    end else begin : g_idZero
      assign m_axis.tid = '0;
    end
    if (DEST_ENABLE != 0) begin : g_destOut
      assign m_axis.tdest = r_mWord[DEST_OFFSET +: DEST_WIDTH];
    end else begin : g_destZero
      assign m_axis.tdest = '0;
    end
    if (USER_ENABLE != 0) begin : g_userOut
      assign m_axis.tuser = r_mWord[USER_OFFSET +: USER_WIDTH];
    end else begin : g_userZero
      assign m_axis.tuser = '0;
    end
  endgenerate

`ifdef AXIS_FIFO_STATUS_EN
  // Registered one-cycle outcome pulses, one per frame event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
    end else begin
      status_overflow   <= w_overflowEvt;
      status_bad_frame  <= w_badEvt;
      status_good_frame <= w_goodEvt;
    end
  end
`else
  assign status_overflow   = 1'b0;
  assign status_bad_frame  = 1'b0;
  assign status_good_frame = 1'b0;
`endif

endmodule

// File: tb/tb_axis_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_fifo
// Scoreboard bench for axis_fifo. Three instances share clk/rst:
//   dut 0 : default frame FIFO (drop when full, bad frames kept)
//   dut 1 : frame FIFO with bad-frame dropping
//   dut 2 : plain (non-frame) FIFO
// Expected beats are queued as stimulus is driven and popped as each DUT
// hands a beat downstream.
// ---------------------------------------------------------------------------
module tb_axis_fifo;

`ifdef AXIS_FIFO_STATUS_EN
  localparam int STATUS_ON = 1;
`else
  localparam int STATUS_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic       sValid [3];
  logic [7:0] sData  [3];
  logic       sLast  [3];
  logic       sUser  [3];
  logic       mReady [3];

  logic ovf0, bad0, good0;
  logic ovf1, bad1, good1;
  logic ovf2, bad2, good2;

  axis_fifo_if sIf0 ();
  axis_fifo_if mIf0 ();
  axis_fifo_if sIf1 ();
  axis_fifo_if mIf1 ();
  axis_fifo_if sIf2 ();
  axis_fifo_if mIf2 ();

  // Upstream drivers and downstream ready for each instance.
  assign sIf0.tvalid = sValid[0];
  assign sIf0.tdata  = sData[0];
  assign sIf0.tlast  = sLast[0];
  assign sIf0.tuser  = sUser[0];
  assign sIf0.tkeep  = '1;
  assign sIf0.tid    = '0;
  assign sIf0.tdest  = '0;
  assign mIf0.tready = mReady[0];

  assign sIf1.tvalid = sValid[1];
  assign sIf1.tdata  = sData[1];
  assign sIf1.tlast  = sLast[1];
  assign sIf1.tuser  = sUser[1];
  assign sIf1.tkeep  = '1;
  assign sIf1.tid    = '0;
  assign sIf1.tdest  = '0;
  assign mIf1.tready = mReady[1];

  assign sIf2.tvalid = sValid[2];
  assign sIf2.tdata  = sData[2];
  assign sIf2.tlast  = sLast[2];
  assign sIf2.tuser  = sUser[2];
  assign sIf2.tkeep  = '1;
  assign sIf2.tid    = '0;
  assign sIf2.tdest  = '0;
  assign mIf2.tready = mReady[2];

  axis_fifo uFrame (
    .clk(clk), .rst(rst), .s_axis(sIf0), .m_axis(mIf0),
    .status_overflow(ovf0), .status_bad_frame(bad0), .status_good_frame(good0)
  );

  axis_fifo #(.DROP_BAD_FRAME(1)) uBad (
    .clk(clk), .rst(rst), .s_axis(sIf1), .m_axis(mIf1),
    .status_overflow(ovf1), .status_bad_frame(bad1), .status_good_frame(good1)
  );

  axis_fifo #(.FRAME_FIFO(0)) uStream (
    .clk(clk), .rst(rst), .s_axis(sIf2), .m_axis(mIf2),
    .status_overflow(ovf2), .status_bad_frame(bad2), .status_good_frame(good2)
  );

  int checkCount = 0;
  int passCount  = 0;

  logic [9:0] expQ0 [$];
  logic [9:0] expQ1 [$];
  logic [9:0] expQ2 [$];

  int ovfCnt0 = 0, badCnt0 = 0, goodCnt0 = 0;
  int ovfCnt1 = 0, badCnt1 = 0, goodCnt1 = 0;
  int notReady0 = 0;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int qSize(input int d);
    case (d)
      0:       return expQ0.size();
      1:       return expQ1.size();
      default: return expQ2.size();
    endcase
  endfunction

  function automatic logic readyOf(input int d);
    case (d)
      0:       return sIf0.tready;
      1:       return sIf1.tready;
      default: return sIf2.tready;
    endcase
  endfunction

  task automatic pushExp(input int d, input logic [9:0] beat);
    case (d)
      0:       expQ0.push_back(beat);
      1:       expQ1.push_back(beat);
      default: expQ2.push_back(beat);
    endcase
  endtask

  // Pop the oldest expected beat for instance d and compare it.
  task automatic scoreBeat(input int d, input logic [7:0] data,
                           input logic last, input logic user);
    logic [9:0] expBeat;
    int         sz;
    sz = qSize(d);
    checkOutput($sformatf("d%0d beat expected", d), 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      case (d)
        0:       expBeat = expQ0.pop_front();
        1:       expBeat = expQ1.pop_front();
        default: expBeat = expQ2.pop_front();
      endcase
      checkOutput($sformatf("d%0d beat {user,last,data}", d),
                  32'({user, last, data}), 32'(expBeat));
    end
  endtask

  // Output monitor and status pulse counters, sampled away from the edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (mIf0.tvalid && mReady[0]) scoreBeat(0, mIf0.tdata, mIf0.tlast, mIf0.tuser[0]);
      if (mIf1.tvalid && mReady[1]) scoreBeat(1, mIf1.tdata, mIf1.tlast, mIf1.tuser[0]);
      if (mIf2.tvalid && mReady[2]) scoreBeat(2, mIf2.tdata, mIf2.tlast, mIf2.tuser[0]);
      if (ovf0)  ovfCnt0++;
      if (bad0)  badCnt0++;
      if (good0) goodCnt0++;
      if (ovf1)  ovfCnt1++;
      if (bad1)  badCnt1++;
      if (good1) goodCnt1++;
      if (!sIf0.tready) notReady0++;
    end
  end

  // Drive one beat into instance d and hold it until accepted.
  task automatic applyStimulus(input int d, input logic [7:0] data, input logic last,
                               input logic user, input logic expectOut);
    logic ok;
    ok = 1'b0;
    sValid[d] = 1'b1;
    sData[d]  = data;
    sLast[d]  = last;
    sUser[d]  = user;
    if (expectOut) pushExp(d, {user, last, data});
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      ok = readyOf(d);
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) checkOutput($sformatf("d%0d tready wait 0x%0h", d, data), 32'(ok), 32'd1);
    sValid[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int d);
    for (int i = 0; i < 200 && qSize(d) != 0; i++) @(posedge clk);
    idle(3);
    checkOutput($sformatf("d%0d drained", d), 32'(qSize(d)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      sValid[d] = 1'b0;
      sData[d]  = '0;
      sLast[d]  = 1'b0;
      sUser[d]  = 1'b0;
      mReady[d] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst m_tvalid", 32'(mIf0.tvalid), 32'd0);
    checkOutput("rst m_tdata", 32'(mIf0.tdata), 32'd0);
    checkOutput("rst m_tlast", 32'(mIf0.tlast), 32'd0);
    checkOutput("rst m_tuser", 32'(mIf0.tuser), 32'd0);
    checkOutput("rst s_tready frame", 32'(sIf0.tready), 32'd1);
    checkOutput("rst s_tready stream", 32'(sIf2.tready), 32'd1);
    checkOutput("rst status", 32'({ovf0, bad0, good0}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Four single-beat frames while downstream is stalled
    applyStimulus(0, 8'd1, 1'b1, 1'b0, 1'b1);
    applyStimulus(0, 8'd1, 1'b1, 1'b0, 1'b1);
    applyStimulus(0, 8'd2, 1'b1, 1'b0, 1'b1);
    applyStimulus(0, 8'd3, 1'b1, 1'b0, 1'b1);
    idle(2);
    checkOutput("d0 head valid while stalled", 32'(mIf0.tvalid), 32'd1);
    checkOutput("d0 head data while stalled", 32'(mIf0.tdata), 32'd1);

    // Overflowing frame: beat 5 finds no room, rest of frame discarded
    // even though the FIFO drains before its tlast arrives.
    applyStimulus(0, 8'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 8'd5, 1'b0, 1'b0, 1'b0);
    mReady[0] = 1'b1;
    applyStimulus(0, 8'd6, 1'b0, 1'b0, 1'b0);
    idle(1);
    applyStimulus(0, 8'd9, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 8'd7, 1'b1, 1'b1, 1'b1);
    waitDrain(0);
    checkOutput("d0 overflow pulses after first drop", 32'(ovfCnt0), 32'(STATUS_ON));

    // Frame longer than the buffer is dropped and nothing reaches m_axis
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'(10 + i), 1'(i == 4), 1'b0, 1'b0);
    idle(3);
    checkOutput("d0 empty after oversize frame", 32'(mIf0.tvalid), 32'd0);
    applyStimulus(0, 8'd15, 1'b1, 1'b0, 1'b1);
    applyStimulus(0, 8'd16, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 8'd17, 1'b1, 1'b0, 1'b1);
    waitDrain(0);
    checkOutput("d0 overflow count", 32'(ovfCnt0), 32'(2 * STATUS_ON));
    checkOutput("d0 good count", 32'(goodCnt0), 32'(7 * STATUS_ON));
    checkOutput("d0 bad count", 32'(badCnt0), 32'd0);
    checkOutput("d0 s_tready never low", 32'(notReady0), 32'd0);

    // Bad-frame dropping on the second instance
    mReady[1] = 1'b1;
    applyStimulus(1, 8'h20, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 8'h21, 1'b1, 1'b1, 1'b0);
    idle(3);
    checkOutput("d1 wrPtr after bad frame", 32'(uBad.r_wrPtr), 32'd0);
    checkOutput("d1 no output after bad frame", 32'(mIf1.tvalid), 32'd0);
    applyStimulus(1, 8'h22, 1'b1, 1'b0, 1'b1);
    applyStimulus(1, 8'h23, 1'b0, 1'b1, 1'b1);
    applyStimulus(1, 8'h24, 1'b1, 1'b0, 1'b1);
    waitDrain(1);
    checkOutput("d1 bad count", 32'(badCnt1), 32'(STATUS_ON));
    checkOutput("d1 good count", 32'(goodCnt1), 32'(2 * STATUS_ON));
    checkOutput("d1 overflow count", 32'(ovfCnt1), 32'd0);

    // Plain FIFO: fill to capacity (4 stored + output register), then
    // drain with a toggling ready while the rest of the stream arrives.
    for (int i = 0; i < 5; i++) applyStimulus(2, 8'(8'h30 + i), 1'(i % 2), 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("d2 s_tready low when full", 32'(sIf2.tready), 32'd0);
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          @(posedge clk);
          #1;
          mReady[2] = ~mReady[2];
        end
      end
      begin
        for (int i = 5; i < 8; i++) applyStimulus(2, 8'(8'h30 + i), 1'(i % 2), 1'b0, 1'b1);
      end
    join
    mReady[2] = 1'b1;
    waitDrain(2);
    checkOutput("d2 s_tready after drain", 32'(sIf2.tready), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/axis_fifo.md
Name: axis_fifo

Overview:
- Synchronous AXI4-Stream FIFO with optional frame (packet) mode.
- Buffers beats carrying tdata/tkeep/tlast/tid/tdest/tuser between an upstream slave port and a downstream master port.
- In frame mode, a frame is visible at the output only once its tlast beat is written.
- Frames that cannot fit, or that are marked bad, are dropped whole; status pulses report each outcome.

Parameters:
- DEPTH, 4, storage entries (beats); power of two, >= 2.
- DATA_WIDTH, 8, tdata width.
- KEEP_ENABLE, (DATA_WIDTH>8), tkeep stored; when 0, m_axis_tkeep is all ones.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- LAST_ENABLE, 1, tlast stored; when 0, m_axis_tlast = 1.
- ID_ENABLE, 0, tid stored; when 0, output is 0.
- ID_WIDTH, 8, tid width.
- DEST_ENABLE, 0, tdest stored; when 0, output is 0.
- DEST_WIDTH, 8, tdest width.
- USER_ENABLE, 1, tuser stored; when 0, output is 0.
- USER_WIDTH, 1, tuser width.
- FRAME_FIFO, 1, enables frame mode.
- USER_BAD_FRAME_VALUE, 1'b1, tuser value that marks a bad frame.
- USER_BAD_FRAME_MASK, 1'b1, bits of tuser compared against USER_BAD_FRAME_VALUE.
- DROP_BAD_FRAME, 0, discard bad frames (frame mode only).
- DROP_WHEN_FULL, 1, always accept input and discard frames that do not fit (frame mode only).

Ports:
- clk in 1 clock
- rst in 1 reset
- s_axis_tdata in DATA_WIDTH
- s_axis_tkeep in KEEP_WIDTH
- s_axis_tvalid in 1
- s_axis_tready out 1
- s_axis_tlast in 1
- s_axis_tid in ID_WIDTH
- s_axis_tdest in DEST_WIDTH
- s_axis_tuser in USER_WIDTH
- m_axis_tdata out DATA_WIDTH
- m_axis_tkeep out KEEP_WIDTH
- m_axis_tvalid out 1
- m_axis_tready in 1
- m_axis_tlast out 1
- m_axis_tid out ID_WIDTH
- m_axis_tdest out DEST_WIDTH
- m_axis_tuser out USER_WIDTH
- status_overflow out 1, one-cycle pulse when a frame is dropped for space
- status_bad_frame out 1, one-cycle pulse when a bad frame is dropped
- status_good_frame out 1, one-cycle pulse when a frame is committed

Interface rule: one clock (clk); rst is asynchronous, active-high, and clears all state.

Behaviour:
- Reset values: pointers 0, drop flag 0, output register empty. m_axis_tvalid=0, m_axis_tdata and sidebands 0, all status outputs 0.
- Pointers have log2(DEPTH)+1 bits; the MSB is the wrap bit. Three pointers: wr_ptr (committed), wr_ptr_cur (speculative), rd_ptr.
- full = (wr_ptr - rd_ptr) == DEPTH. full_cur = (wr_ptr_cur - rd_ptr) == DEPTH. full_wr = (wr_ptr_cur - wr_ptr) == DEPTH. empty = wr_ptr == rd_ptr.
- s_axis_tready:
  - non-frame mode: !full.
  - frame mode: !full_cur || full_wr || DROP_WHEN_FULL.
- A transfer is accepted when s_axis_tvalid && s_axis_tready.
- Non-frame mode: each accepted beat is written at wr_ptr and wr_ptr increments.
- Frame mode, per accepted beat:
  - drop_frame set: write nothing; on tlast, clear drop_frame.
  - else if full_cur or full_wr: set drop_frame, restore wr_ptr_cur to wr_ptr in the same cycle, pulse status_overflow. If this beat has tlast, clear drop_frame immediately.
  - else: write the beat at wr_ptr_cur and increment it. On tlast:
    - if DROP_BAD_FRAME and (tuser & MASK) == (VALUE & MASK): restore wr_ptr_cur to wr_ptr and pulse status_bad_frame.
    - otherwise: wr_ptr <= wr_ptr_cur + 1 and pulse status_good_frame.
- Once a frame begins dropping, every remaining beat up to and including tlast is discarded, even if space frees up in the meantime.
- Read side: a one-entry output register. When it is empty or being consumed (m_axis_tready) and !empty, load mem[rd_ptr] and increment rd_ptr. m_axis_tvalid rises one cycle after the entry becomes committed.
- Simultaneous read and write are allowed; full and empty use the pre-edge pointers.
- Wrap-around is handled by the pointer MSB. Frames may straddle the end of the buffer.

Optional Feature:
- Macro AXIS_FIFO_STATUS_EN.
- Defined: status_overflow, status_bad_frame and status_good_frame are registered pulses as described above.
- Undefined: all three outputs are tied 0 and their logic is removed. Data path behaviour is unchanged.

Test Plan:
- After rst release, write four single-beat frames (data 1,1,2,3, tlast=1) with m_axis_tready=0. Then enable m_axis_tready -> outputs 1,1,2,3 in order, each with tlast=1; status_good_frame pulses 4 times.
- With the FIFO full of four committed frames, send beats 4,5,6 with tlast=0. Stall tvalid for one cycle, then resume with tlast on a later beat, while m_axis_tready=1 drains the FIFO -> s_axis_tready stays 1, one status_overflow pulse, data 4/5/6 never appear on m_axis.
- After that drop, send a single-beat frame with data 7 -> m_axis outputs 7 with tlast=1.
- DROP_BAD_FRAME=1: send a 2-beat frame with tuser=1 on its tlast beat -> status_bad_frame pulses, no output, wr_ptr unchanged.
- Send a 5-beat frame into an empty DEPTH=4 FIFO -> full_wr triggers a drop, status_overflow pulses, the FIFO stays empty, and the next frame passes normally.
- FRAME_FIFO=0: stream 8 beats with m_axis_tready toggling -> data emerges in order with none lost; s_axis_tready=0 only while 4 entries are held.
